// File: rtl/msrr8_seq_ctrl.sv
// msrr8_seq_ctrl: command sequencer for the 8-bit multi-mode shift register.
// Each accepted command is expanded into the per-cycle sIn/mode/inz stream that
// the register consumes, followed by a one-cycle done pulse.
//
// Handshake: a command is transferred on a rising clk edge where
// cmd_valid & cmd_ready are both high. cmd_ready is high only in IDLE and
// only while Re is low. cmd_op/cmd_data/cmd_len are captured at that edge,
// and they are ignored at every other time.
module msrr8_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             Re,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             sIn,
   output logic [1:0]       mode,
   output logic             inz,
   output logic             busy,
   output logic             done,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLR   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OP_CLEAR  = 2'b00;
   localparam logic [1:0] OP_LOAD_R = 2'b01;
   localparam logic [1:0] OP_LOAD_L = 2'b10;

   localparam logic [1:0] M_HOLD  = 2'b00;
   localparam logic [1:0] M_RIGHT = 2'b01;
   localparam logic [1:0] M_LEFT  = 2'b10;
   localparam logic [1:0] M_ROT   = 2'b11;

   // One extra bit so both WIDTH and the largest cmd_len fit.
   localparam logic [LEN_W:0] LOAD_COUNT = (LEN_W + 1)'(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] shadow;  // bits still to be serialized
   logic [LEN_W:0]   cnt;     // drive cycles left, counting down to 1

   assign fsm_state = state;

   // Ready is combinational on Re so a command is never taken during reset.
   assign cmd_ready = (state == S_IDLE) & ~Re;

   // Sequencer FSM; every stream output is registered here.
   always_ff @(posedge clk) begin
      if (Re) begin
         state  <= S_IDLE;
         shadow <= '0;
         cnt    <= '0;
         sIn    <= 1'b0;
         mode   <= M_HOLD;
         inz    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               sIn  <= 1'b0;
               mode <= M_HOLD;
               inz  <= 1'b0;
               done <= 1'b0;
               busy <= 1'b0;
               if (cmd_valid) begin
                  busy <= 1'b1;
                  case (cmd_op)
                     OP_CLEAR: begin
                        state <= S_CLR;
                        inz   <= 1'b1;
                     end
                     OP_LOAD_R: begin
                        // LSB goes out first; the rest waits in the shadow.
                        state  <= S_SHIFT;
                        mode   <= M_RIGHT;
                        sIn    <= cmd_data[0];
                        shadow <= cmd_data >> 1;
                        cnt    <= LOAD_COUNT;
                     end
                     OP_LOAD_L: begin
                        // MSB goes out first.
                        state  <= S_SHIFT;
                        mode   <= M_LEFT;
                        sIn    <= cmd_data[WIDTH-1];
                        shadow <= cmd_data << 1;
                        cnt    <= LOAD_COUNT;
                     end
                     default: begin
                        // A zero-length rotate has nothing to drive.
                        if (cmd_len == '0) begin
                           state <= S_DONE;
                           done  <= 1'b1;
                        end else begin
                           state <= S_SHIFT;
                           mode  <= M_ROT;
                           cnt   <= {1'b0, cmd_len};
                        end
                     end
                  endcase
               end
            end

            S_CLR: begin
               state <= S_DONE;
               inz   <= 1'b0;
               done  <= 1'b1;
            end

            S_SHIFT: begin
               if (cnt == (LEN_W + 1)'(1)) begin
                  state <= S_DONE;
                  mode  <= M_HOLD;
                  sIn   <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
                  case (mode)
                     M_RIGHT: begin
                        sIn    <= shadow[0];
                        shadow <= shadow >> 1;
                     end
                     M_LEFT: begin
                        sIn    <= shadow[WIDTH-1];
                        shadow <= shadow << 1;
                     end
                     default: sIn <= 1'b0;
                  endcase
               end
            end

            default: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
